// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read / one-write register file with a per-register
// scoreboard for read-after-write hazard detection.
//
// Register 0 always reads zero, is never busy, and ignores writes and
// reserves. A reserve marks a destination register busy, and a write clears
// that busy bit. busy_count always holds the popcount of the busy vector.
//
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward the write port to
// RD1/RD2/cpu_out in the same cycle. Without it, reads show only array state.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   RA1/RA2          read addresses; RD1/RD2 combinational read data
//   RD1_busy/RD2_busy busy bit of the addressed register; hazard = OR of both
//   WA/ALUResult/write_enable  write port (commits data, clears busy)
//   RES_A/reserve_en reserve port (sets busy)
//   busy_count       registered count of busy registers
//   cpu_out          contents of register OUT_IDX
module reg_file_sb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int OUT_IDX = 2**ADDR_W-1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              RD1_busy,
    output logic              RD2_busy,
    output logic              hazard,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] RES_A,
    input  logic              reserve_en,
    output logic [ADDR_W:0]   busy_count,
    output logic [DATA_W-1:0] cpu_out
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_A   = ADDR_W'(OUT_IDX);
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wr_ok;
    logic rs_ok;
    logic cnt_inc;
    logic cnt_dec;

    // Reset discards any same-cycle write or reserve, including the
    // forwarded value when bypass is enabled.
    assign wr_ok = write_enable && (WA != '0) && !RST;
    assign rs_ok = reserve_en && (RES_A != '0) && !RST;

    // Count moves only when a bit actually changes. A write that clears a
    // bit the same-cycle reserve sets again leaves that bit unchanged.
    assign cnt_inc = rs_ok && !busy[RES_A];
    assign cnt_dec = wr_ok && busy[WA] && !(rs_ok && (RES_A == WA));

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok) begin
                regs[WA] <= ALUResult;
                busy[WA] <= 1'b0;
            end
            // Placed after the write so that the new producer wins on the
            // same address.
            if (rs_ok) busy[RES_A] <= 1'b1;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_count <= busy_count + CNT_ONE;
                2'b01:   busy_count <= busy_count - CNT_ONE;
                default: busy_count <= busy_count;
            endcase
        end
    end

`ifdef REG_FILE_SB_BYPASS_EN
    logic byp1;
    logic byp2;
    logic bypo;

    assign byp1     = wr_ok && (WA == RA1);
    assign byp2     = wr_ok && (WA == RA2);
    assign bypo     = wr_ok && (WA == OUT_A);
    assign RD1      = byp1 ? ALUResult : regs[RA1];
    assign RD2      = byp2 ? ALUResult : regs[RA2];
    assign RD1_busy = byp1 ? 1'b0 : busy[RA1];
    assign RD2_busy = byp2 ? 1'b0 : busy[RA2];
    assign cpu_out  = bypo ? ALUResult : regs[OUT_A];
`else
    assign RD1      = regs[RA1];
    assign RD2      = regs[RA2];
    assign RD1_busy = busy[RA1];
    assign RD2_busy = busy[RA2];
    assign cpu_out  = regs[OUT_A];
`endif

    assign hazard = RD1_busy | RD2_busy;

endmodule
